// File: rtl/mem_port_scheduler_pkg.sv
// Shared definitions for the memory port scheduler.
//   log2(n) : ceiling log2 with a floor of 1, used to size port indices.
package mem_port_scheduler_pkg;

    function automatic int unsigned log2(input int unsigned n);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) begin
                w = i + 1;
            end
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/mem_port_scheduler_if.sv
// Bundle of requester-side and memory-side signals for mem_port_scheduler.
//   master : the scheduler view (accepts requests, drives responses and the
//            memory request channel, receives memory responses).
//   slave  : the environment view (requesters plus memory).
// Request fields are flattened; port i lives at [i*WIDTH +: WIDTH].
interface mem_port_scheduler_if
    import mem_port_scheduler_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();

    logic [NUM_PORTS-1:0]            req_valid;
    logic [NUM_PORTS-1:0]            req_write;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_PORTS-1:0]            req_ready;
    logic [NUM_PORTS-1:0]            resp_valid;
    logic [DATA_WIDTH-1:0]           resp_rdata;

    logic                            mem_valid;
    logic                            mem_write;
    logic [ADDR_WIDTH-1:0]           mem_addr;
    logic [DATA_WIDTH-1:0]           mem_wdata;
    logic                            mem_ready;
    logic                            mem_resp_valid;
    logic [DATA_WIDTH-1:0]           mem_rdata;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata,
        output mem_valid, mem_write, mem_addr, mem_wdata,
        input  mem_ready, mem_resp_valid, mem_rdata
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata,
        input  mem_valid, mem_write, mem_addr, mem_wdata,
        output mem_ready, mem_resp_valid, mem_rdata
    );

endinterface

// File: rtl/mem_port_scheduler_rr_select.sv
// Round-robin selector (purely combinational).
//   requests_i  : per-port request bits
//   ptr_i       : index of the most recently granted port
//   grant_o     : lowest requesting index above ptr_i, else lowest overall
//   any_valid_o : at least one request present
module mem_port_scheduler_rr_select
    import mem_port_scheduler_pkg::*;
#(
    parameter int          NUM_PORTS = 4,
    parameter int unsigned IDX_W     = log2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] requests_i,
    input  logic [IDX_W-1:0]     ptr_i,
    output logic [IDX_W-1:0]     grant_o,
    output logic                 any_valid_o
);

    logic found;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        // Masked pass: only ports strictly above the pointer.
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!found && requests_i[i] && (i > int'(ptr_i))) begin
                grant_o = IDX_W'(i);
                found   = 1'b1;
            end
        end
        // Wrap pass: nothing above the pointer, take the lowest request.
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!found && requests_i[i]) begin
                grant_o = IDX_W'(i);
                found   = 1'b1;
            end
        end
    end

    assign any_valid_o = |requests_i;

endmodule

// File: rtl/mem_port_scheduler.sv
// Shares one single-outstanding memory port between NUM_PORTS requesters
// with round-robin fairness.
//   clock_i    : system clock, rising edge
//   reset_i    : synchronous active-high reset
//   bus_io     : requester handshake, response pulse and memory channel
//   grant_id_o : port owning the current transaction
//   busy_o     : high whenever the scheduler is not idle
module mem_port_scheduler
    import mem_port_scheduler_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                         clock_i,
    input  logic                         reset_i,
    mem_port_scheduler_if.master         bus_io,
    output logic [log2(NUM_PORTS)-1:0]   grant_id_o,
    output logic                         busy_o
);

    localparam int unsigned IDX_W = log2(NUM_PORTS);
    localparam logic [NUM_PORTS-1:0] ONE_HOT0 = {{(NUM_PORTS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_RESP = 2'd2,
        S_RESPOND   = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]       grant_q, grant_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic                   write_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [DATA_WIDTH-1:0]  wdata_q;

    logic [IDX_W-1:0]       sel_idx;
    logic                   any_valid;
    logic                   accept;
    logic [NUM_PORTS-1:0]   ready_c;
    logic                   sel_write;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [DATA_WIDTH-1:0]  sel_wdata;

    mem_port_scheduler_rr_select #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_rr_select (
        .requests_i  (bus_io.req_valid),
        .ptr_i       (rr_ptr_q),
        .grant_o     (sel_idx),
        .any_valid_o (any_valid)
    );

    // Fields of the port the selector picked this cycle.
    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (sel_idx == IDX_W'(i)) begin
                sel_write = bus_io.req_write[i];
                sel_addr  = bus_io.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = bus_io.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        rdata_d  = rdata_q;
        ready_c  = '0;
        accept   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (any_valid) begin
                    ready_c  = ONE_HOT0 << sel_idx;
                    accept   = 1'b1;
                    rr_ptr_d = sel_idx;
                    grant_d  = sel_idx;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus_io.mem_ready) begin
                    // A response in the accept cycle skips WAIT_RESP.
                    if (bus_io.mem_resp_valid) begin
                        rdata_d = bus_io.mem_rdata;
                        state_d = S_RESPOND;
                    end else begin
                        state_d = S_WAIT_RESP;
                    end
                end
            end
            S_WAIT_RESP: begin
                if (bus_io.mem_resp_valid) begin
                    rdata_d = bus_io.mem_rdata;
                    state_d = S_RESPOND;
                end
            end
            S_RESPOND: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= IDX_W'(NUM_PORTS - 1);
            grant_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            rdata_q  <= rdata_d;
        end
    end

    // Request payload is only meaningful in ISSUE, so it needs no reset.
    always_ff @(posedge clock_i) begin
        if (accept) begin
            write_q <= sel_write;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
        end
    end

    // Memory-side outputs are zeroed outside ISSUE so nothing leaks while idle.
    assign bus_io.req_ready  = reset_i ? '0 : ready_c;
    assign bus_io.resp_valid = (state_q == S_RESPOND) ? (ONE_HOT0 << grant_q) : '0;
    assign bus_io.resp_rdata = rdata_q;
    assign bus_io.mem_valid  = (state_q == S_ISSUE);
    assign bus_io.mem_write  = (state_q == S_ISSUE) & write_q;
    assign bus_io.mem_addr   = (state_q == S_ISSUE) ? addr_q  : '0;
    assign bus_io.mem_wdata  = (state_q == S_ISSUE) ? wdata_q : '0;
    assign grant_id_o        = grant_q;
    assign busy_o            = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_port_scheduler.sv
module tb_mem_port_scheduler;
    import mem_port_scheduler_pkg::*;

    localparam int NP = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [31:0] RD_KEY = 32'hA5A5_0000;

    logic       clock_i;
    logic       reset_i;
    logic [1:0] grant_id;
    logic       busy;

    mem_port_scheduler_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_port_scheduler #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .bus_io     (bus),
        .grant_id_o (grant_id),
        .busy_o     (busy)
    );

    typedef struct {
        int          port;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    task automatic next_cycle();
        @(posedge clock_i);
        #1;
    endtask

    task automatic sample();
        @(negedge clock_i);
    endtask

    task automatic set_port(input int p, input logic wr, input logic [31:0] a, input logic [31:0] d);
        bus.req_write[p]          = wr;
        bus.req_addr[p*AW +: AW]  = a;
        bus.req_wdata[p*DW +: DW] = d;
    endtask

    task automatic idle_inputs();
        bus.req_valid      = '0;
        bus.req_write      = '0;
        bus.req_addr       = '0;
        bus.req_wdata      = '0;
        bus.mem_ready      = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = '0;
    endtask

    task automatic do_reset();
        next_cycle();
        reset_i = 1'b1;
        idle_inputs();
        next_cycle();
        next_cycle();
        reset_i = 1'b0;
    endtask

    // Scoreboard: every response pulse must match the oldest expectation.
    initial begin : monitor
        exp_t        e;
        logic [3:0]  want;
        forever begin
            @(negedge clock_i);
            if (reset_i === 1'b0 && bus.resp_valid !== 4'b0000) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected resp_valid=%b rdata=%h required no response", bus.resp_valid, bus.resp_rdata);
                end else begin
                    e    = exp_q.pop_front();
                    want = 4'b0001 << e.port;
                    if (bus.resp_valid !== want || bus.resp_rdata !== e.data) begin
                        failures++;
                        $display("FAIL sb_resp got valid=%b rdata=%h required valid=%b rdata=%h",
                                 bus.resp_valid, bus.resp_rdata, want, e.data);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        reset_i = 1'b1;
        idle_inputs();
        for (int i = 0; i < NP; i++) set_port(i, 1'b0, 32'h10 * i, 32'h0);
        bus.req_valid = 4'b1111;
        repeat (3) next_cycle();
        sample();
        checks++;
        if (bus.req_ready !== 4'b0000) begin
            failures++; $display("FAIL reset_req_ready got %b required 0000", bus.req_ready);
        end
        checks++;
        if (bus.mem_valid !== 1'b0) begin
            failures++; $display("FAIL reset_mem_valid got %b required 0", bus.mem_valid);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL reset_busy got %b required 0", busy);
        end
        checks++;
        if (bus.resp_valid !== 4'b0000 || grant_id !== 2'd0 || bus.resp_rdata !== 32'h0) begin
            failures++; $display("FAIL reset_outputs got resp_valid=%b grant=%0d rdata=%h required 0", bus.resp_valid, grant_id, bus.resp_rdata);
        end
        next_cycle();
        reset_i = 1'b0;
        sample();
        checks++;
        if (bus.req_ready !== 4'b0001) begin
            failures++; $display("FAIL reset_first_grant got %b required 0001", bus.req_ready);
        end
        bus.req_valid = '0;
    endtask

    task automatic test_read_latency();
        next_cycle();
        set_port(2, 1'b0, 32'h100, 32'h0);
        bus.req_valid = 4'b0100;
        sample();
        checks++;
        if (bus.req_ready !== 4'b0100) begin
            failures++; $display("FAIL rd_accept got %b required 0100", bus.req_ready);
        end
        exp_q.push_back('{port: 2, data: 32'hDEAD_BEEF});
        next_cycle();
        bus.req_valid = '0;
        set_port(2, 1'b0, 32'h0, 32'h0);
        bus.mem_ready = 1'b1;
        sample();
        checks++;
        if (bus.mem_valid !== 1'b1 || bus.mem_addr !== 32'h100 || bus.mem_write !== 1'b0 || grant_id !== 2'd2 || busy !== 1'b1) begin
            failures++;
            $display("FAIL rd_issue got valid=%b addr=%h write=%b grant=%0d busy=%b required 1 00000100 0 2 1",
                     bus.mem_valid, bus.mem_addr, bus.mem_write, grant_id, busy);
        end
        next_cycle();
        bus.mem_ready      = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'hDEAD_BEEF;
        sample();
        checks++;
        if (bus.mem_valid !== 1'b0 || bus.resp_valid !== 4'b0000) begin
            failures++; $display("FAIL rd_wait got mem_valid=%b resp_valid=%b required 0 0000", bus.mem_valid, bus.resp_valid);
        end
        next_cycle();
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = '0;
        sample();
        checks++;
        if (bus.resp_valid !== 4'b0100 || bus.resp_rdata !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL rd_respond got %b %h required 0100 deadbeef", bus.resp_valid, bus.resp_rdata);
        end
        next_cycle();
        sample();
        checks++;
        if (busy !== 1'b0 || bus.resp_valid !== 4'b0000) begin
            failures++; $display("FAIL rd_idle got busy=%b resp_valid=%b required 0 0000", busy, bus.resp_valid);
        end
    endtask

    task automatic test_round_robin();
        int          order[6] = '{0, 1, 2, 3, 0, 2};
        int          n_acc;
        int          last_acc;
        int          p;
        bit          drop1;
        bit          nxt_resp;
        logic [31:0] nxt_data;
        logic [3:0]  hs;
        n_acc    = 0;
        last_acc = 0;
        drop1    = 1'b0;
        do_reset();
        for (int i = 0; i < NP; i++) set_port(i, 1'b0, 32'h1000 + 32'h10 * i, 32'h0);
        bus.req_valid = 4'b1111;
        bus.mem_ready = 1'b1;
        for (int cyc = 0; cyc < 32; cyc++) begin
            sample();
            hs       = bus.req_valid & bus.req_ready;
            nxt_resp = bus.mem_valid && bus.mem_ready;
            nxt_data = bus.mem_addr ^ RD_KEY;
            if (hs != 4'b0000) begin
                p = 0;
                for (int i = 0; i < NP; i++) if (hs[i]) p = i;
                checks++;
                if (n_acc >= 6 || p != order[n_acc]) begin
                    failures++; $display("FAIL rr_order accept#%0d got port %0d required %0d", n_acc, p, (n_acc < 6) ? order[n_acc] : -1);
                end
                if (n_acc > 0) begin
                    checks++;
                    if (cyc - last_acc != 4) begin
                        failures++; $display("FAIL rr_spacing accept#%0d got %0d cycles required 4", n_acc, cyc - last_acc);
                    end
                end
                exp_q.push_back('{port: p, data: (32'h1000 + 32'h10 * p) ^ RD_KEY});
                if (p == 1) drop1 = 1'b1;
                last_acc = cyc;
                n_acc++;
            end
            next_cycle();
            if (drop1) bus.req_valid[1] = 1'b0;
            if (n_acc >= 6) bus.req_valid = '0;
            bus.mem_resp_valid = nxt_resp;
            bus.mem_rdata      = nxt_resp ? nxt_data : 32'h0;
        end
        checks++;
        if (n_acc != 6 || exp_q.size() != 0) begin
            failures++; $display("FAIL rr_complete got accepts=%0d pending=%0d required 6 0", n_acc, exp_q.size());
        end
        bus.mem_ready      = 1'b0;
        bus.mem_resp_valid = 1'b0;
    endtask

    task automatic test_write_stall();
        next_cycle();
        set_port(1, 1'b1, 32'h40, 32'h1234);
        bus.req_valid = 4'b0010;
        sample();
        checks++;
        if (bus.req_ready !== 4'b0010) begin
            failures++; $display("FAIL wr_accept got %b required 0010", bus.req_ready);
        end
        exp_q.push_back('{port: 1, data: 32'h0BAD_F00D});
        next_cycle();
        set_port(1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            bus.mem_ready = (k == 5);
            sample();
            checks++;
            if ({bus.mem_valid, bus.mem_write, bus.mem_addr, bus.mem_wdata, bus.req_ready} !==
                {1'b1, 1'b1, 32'h40, 32'h1234, 4'b0000}) begin
                failures++;
                $display("FAIL wr_stall cycle %0d got valid=%b write=%b addr=%h wdata=%h ready=%b required 1 1 00000040 00001234 0000",
                         k + 1, bus.mem_valid, bus.mem_write, bus.mem_addr, bus.mem_wdata, bus.req_ready);
            end
            next_cycle();
        end
        bus.mem_ready      = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'h0BAD_F00D;
        sample();
        checks++;
        if (bus.mem_valid !== 1'b0 || bus.req_ready !== 4'b0000) begin
            failures++; $display("FAIL wr_wait got mem_valid=%b ready=%b required 0 0000", bus.mem_valid, bus.req_ready);
        end
        next_cycle();
        bus.mem_resp_valid = 1'b0;
        bus.req_valid      = '0;
        sample();
        checks++;
        if (bus.resp_valid !== 4'b0010) begin
            failures++; $display("FAIL wr_respond got %b required 0010", bus.resp_valid);
        end
        next_cycle();
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'h0000_0077;
        sample();
        next_cycle();
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = '0;
        sample();
        checks++;
        if (busy !== 1'b0 || bus.resp_valid !== 4'b0000 || bus.resp_rdata !== 32'h0BAD_F00D) begin
            failures++; $display("FAIL idle_ignore_resp got busy=%b resp_valid=%b rdata=%h required 0 0000 0badf00d",
                                 busy, bus.resp_valid, bus.resp_rdata);
        end
    endtask

    task automatic test_same_cycle();
        int pulses;
        pulses = 0;
        next_cycle();
        set_port(3, 1'b0, 32'h200, 32'h0);
        bus.req_valid = 4'b1000;
        sample();
        checks++;
        if (bus.req_ready !== 4'b1000) begin
            failures++; $display("FAIL sc_accept got %b required 1000", bus.req_ready);
        end
        exp_q.push_back('{port: 3, data: 32'hCAFE_F00D});
        next_cycle();
        bus.req_valid      = '0;
        bus.mem_ready      = 1'b1;
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'hCAFE_F00D;
        sample();
        checks++;
        if (bus.mem_valid !== 1'b1 || bus.mem_addr !== 32'h200) begin
            failures++; $display("FAIL sc_issue got valid=%b addr=%h required 1 00000200", bus.mem_valid, bus.mem_addr);
        end
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            bus.mem_ready      = 1'b0;
            bus.mem_resp_valid = 1'b0;
            bus.mem_rdata      = '0;
            sample();
            if (bus.resp_valid !== 4'b0000) pulses++;
            if (k == 0) begin
                checks++;
                if (bus.resp_valid !== 4'b1000 || bus.resp_rdata !== 32'hCAFE_F00D) begin
                    failures++; $display("FAIL sc_respond got %b %h required 1000 cafef00d", bus.resp_valid, bus.resp_rdata);
                end
            end
        end
        checks++;
        if (pulses != 1 || busy !== 1'b0) begin
            failures++; $display("FAIL sc_single_pulse got pulses=%0d busy=%b required 1 0", pulses, busy);
        end
    endtask

    task automatic test_reset_mid();
        next_cycle();
        set_port(3, 1'b1, 32'h300, 32'h55);
        bus.req_valid = 4'b1000;
        sample();
        checks++;
        if (bus.req_ready !== 4'b1000) begin
            failures++; $display("FAIL rm_accept got %b required 1000", bus.req_ready);
        end
        next_cycle();
        bus.req_valid = '0;
        bus.mem_ready = 1'b1;
        sample();
        next_cycle();
        bus.mem_ready      = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'h1111_2222;
        reset_i            = 1'b1;
        sample();
        checks++;
        if (busy !== 1'b1 || bus.mem_valid !== 1'b0) begin
            failures++; $display("FAIL rm_in_wait got busy=%b mem_valid=%b required 1 0", busy, bus.mem_valid);
        end
        next_cycle();
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = '0;
        for (int i = 0; i < NP; i++) set_port(i, 1'b0, 32'h10 * i, 32'h0);
        bus.req_valid = 4'b1111;
        sample();
        checks++;
        if (busy !== 1'b0 || bus.resp_valid !== 4'b0000 || bus.mem_valid !== 1'b0 || bus.req_ready !== 4'b0000) begin
            failures++; $display("FAIL rm_after_reset got busy=%b resp_valid=%b mem_valid=%b ready=%b required 0 0000 0 0000",
                                 busy, bus.resp_valid, bus.mem_valid, bus.req_ready);
        end
        next_cycle();
        reset_i = 1'b0;
        sample();
        checks++;
        if (bus.req_ready !== 4'b0001) begin
            failures++; $display("FAIL rm_next_grant got %b required 0001", bus.req_ready);
        end
        bus.req_valid = '0;
        next_cycle();
        sample();
        checks++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            failures++; $display("FAIL rm_quiet got busy=%b pending=%0d required 0 0", busy, exp_q.size());
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_i = 1'b1;
        idle_inputs();
        test_reset();
        test_read_latency();
        test_round_robin();
        test_write_stall();
        test_same_cycle();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL sb_drain got pending=%0d required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
